// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router.
// Stores packet bytes with a header tag; registered read port.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int PTR_W = 4
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             header_out,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [WIDTH-1:0] r_dout;
  logic             r_hdr;
  logic             r_valid;

  logic             w_clr;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [PTR_W-1:0] w_wr_addr;
  logic [PTR_W-1:0] w_rd_addr;

  assign w_clr     = reset | soft_reset;
  assign w_wr_addr = r_wr_ptr[PTR_W-1:0];
  assign w_rd_addr = r_rd_ptr[PTR_W-1:0];
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (w_wr_addr == w_rd_addr) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

  // Accepts are judged on pre-edge flags only.
  assign w_wr_acc  = write_enb & ~w_full & ~w_clr;
  assign w_rd_acc  = read_enb & ~w_empty & ~w_clr;

  always_ff @(posedge clk1) begin
    if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
      r_hdr    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr         <= r_rd_ptr + ONE;
        {r_hdr, r_dout}  <= r_mem[w_rd_addr];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (w_wr_acc) begin
      r_mem[w_wr_addr] <= {lfd_state, data_in};
    end
  end

  assign data_out   = r_dout;
  assign header_out = r_hdr;
  assign data_valid = r_valid;
  assign empty      = w_empty;
  assign full       = w_full;
  assign count      = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_router_fifo.sv
// Bench for router_fifo: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clk1 = 1'b0;
  logic       reset = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic       read_enb = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       header_out;
  logic       empty;
  logic       full;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  logic [8:0] q[$];
  logic [7:0] m_dout;
  logic       m_hdr;
  logic       m_val;

  router_fifo #(.DEPTH(16), .WIDTH(8), .PTR_W(4)) dut (
    .clk1      (clk1),
    .reset     (reset),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .read_enb  (read_enb),
    .data_out  (data_out),
    .data_valid(data_valid),
    .header_out(header_out),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic sr,
                     input logic we, input logic lf,
                     input logic [7:0] din, input logic re);
    bit pre_full, pre_empty;
    logic [8:0] e;
    reset      = rs;
    soft_reset = sr;
    write_enb  = we;
    lfd_state  = lf;
    data_in    = din;
    read_enb   = re;
    @(posedge clk1);
    if (rs || sr) begin
      q.delete();
      m_dout = '0;
      m_hdr  = 1'b0;
      m_val  = 1'b0;
    end else begin
      pre_full  = (q.size() == DEPTH);
      pre_empty = (q.size() == 0);
      m_val = re && !pre_empty;
      if (m_val) begin
        e = q.pop_front();
        m_dout = e[7:0];
        m_hdr  = e[8];
      end
      if (we && !pre_full) q.push_back({lf, din});
    end
    #1;
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("valid", data_valid, m_val);
    chk("dout", data_out, m_dout);
    chk("hdr", header_out, m_hdr);
  endtask

  task automatic wr(input logic [7:0] d, input logic lf);
    cyc(0, 0, 1, lf, d, 0);
  endtask

  task automatic rd();
    cyc(0, 0, 0, 0, 8'h00, 1);
  endtask

  initial begin
    logic [7:0] d;
    // reset and idle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 8'h00);
    cyc(0, 0, 0, 0, 0, 0);

    // basic packet
    wr(8'h45, 1);
    wr(8'hA1, 0);
    wr(8'hA2, 0);
    rd();
    chk("pkt_b0", data_out, 8'h45);
    chk("pkt_h0", header_out, 1);
    rd();
    chk("pkt_b1", data_out, 8'hA1);
    chk("pkt_h1", header_out, 0);
    rd();
    chk("pkt_b2", data_out, 8'hA2);
    chk("pkt_v2", data_valid, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pkt_v_end", data_valid, 0);
    chk("pkt_empty", empty, 1);

    // full boundary
    for (int i = 0; i < 16; i++) wr(8'(i), i == 0);
    chk("full_flag", full, 1);
    chk("full_cnt", count, 16);
    wr(8'hFF, 0);
    chk("full_drop", count, 16);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("full_rd", data_out, i);
    end
    chk("full_empty", empty, 1);

    // simultaneous access at count 5
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 8'h20 + 8'(i), 1);
      chk("sim_rd", data_out, 8'h10 + i);
    end
    chk("sim_cnt5", count, 5);
    // simultaneous at full: write dropped
    for (int i = 0; i < 11; i++) wr(8'h30 + 8'(i), 0);
    chk("sim_full", full, 1);
    cyc(0, 0, 1, 0, 8'hEE, 1);
    chk("sim_cnt15", count, 15);
    while (!empty) rd();
    // simultaneous at empty: read ignored
    cyc(0, 0, 1, 1, 8'h5A, 1);
    chk("sim_e_val", data_valid, 0);
    chk("sim_e_cnt", count, 1);
    rd();
    chk("sim_e_rd", data_out, 8'h5A);

    // wrap-around
    for (int i = 0; i < 40; i++) begin
      d = 8'h80 + 8'(i);
      wr(d, i[0]);
      rd();
      chk("wrap_d", data_out, d);
    end

    // flush with concurrent requests
    for (int i = 0; i < 7; i++) wr(8'h60 + 8'(i), 0);
    cyc(0, 1, 1, 0, 8'h99, 1);
    chk("fl_cnt", count, 0);
    chk("fl_val", data_valid, 0);
    wr(8'hAB, 1);
    rd();
    chk("fl_rt", data_out, 8'hAB);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 99) < 55,
          $urandom_range(0, 3) == 0,
          8'($urandom),
          $urandom_range(0, 99) < 45);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
